// File: rtl/slice_serial_subtractor.sv
// Sequential subtractor: diff = a - b - bin, evaluated SLICE bits per clock
// with the borrow registered between slices; start/busy/done framed.
module slice_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state_o
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is honoured only in IDLE and operands are captured on
  // that edge; busy covers the N slice cycles, done is a one-cycle pulse after
  // the last slice with results already valid; busy and done never overlap.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic             ovf_q, ovf_d, zero_q, zero_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SLICE:0]   slice_res;
  logic             last_slice;

  always_comb begin
    slice_res  = {1'b0, a_q[k_q*SLICE +: SLICE]} - {1'b0, b_q[k_q*SLICE +: SLICE]}
               - {{SLICE{1'b0}}, borrow_q};
    last_slice = (k_q == KW'(N - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          k_d      = '0;
          work_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        work_d[k_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
        borrow_d = slice_res[SLICE];
        k_d      = k_q + KW'(1);
        // Architectural results move only on the final slice edge.
        if (last_slice) begin
          state_d = DONE;
          diff_d  = work_d;
          bout_d  = slice_res[SLICE];
          zero_d  = (work_d == '0);
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (work_d[WIDTH-1] ^ a_q[WIDTH-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule
